// File: rtl/franken_pkg.sv
// franken_pkg: shared encodings for the franken multicycle control unit
package franken_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_ITYPEEX = 4'd7,
      S_JEX     = 4'd8,
      S_ALUWB   = 4'd9,
      S_BEQX    = 4'd10,
      S_JALREX  = 4'd11,
      S_JALRWB  = 4'd12,
      S_UEX     = 4'd13,
      S_TRAP    = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] A_PC    = 2'b00;
   localparam logic [1:0] A_OLDPC = 2'b01;
   localparam logic [1:0] A_RS1   = 2'b10;
   localparam logic [1:0] A_ZERO  = 2'b11;

   localparam logic [1:0] B_RS2  = 2'b00;
   localparam logic [1:0] B_IMM  = 2'b01;
   localparam logic [1:0] B_FOUR = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // one-hot instruction class; illegal is set when no other class matches
   typedef struct packed {
      logic load;
      logic store;
      logic rtype;
      logic itype;
      logic jal;
      logic jalr;
      logic branch;
      logic lui;
      logic auipc;
      logic illegal;
   } iclass_t;

endpackage

// File: rtl/franken_op_decode.sv
// franken_op_decode: opcode to one-hot instruction class
module franken_op_decode
   import franken_pkg::*;
(
   input  logic [6:0] opcode,
   output iclass_t    cls
);

   assign cls.load    = (opcode == OP_LOAD);
   assign cls.store   = (opcode == OP_STORE);
   assign cls.rtype   = (opcode == OP_RTYPE);
   assign cls.itype   = (opcode == OP_ITYPE);
   assign cls.jal     = (opcode == OP_JAL);
   assign cls.jalr    = (opcode == OP_JALR);
   assign cls.branch  = (opcode == OP_BRANCH);
   assign cls.lui     = (opcode == OP_LUI);
   assign cls.auipc   = (opcode == OP_AUIPC);
   assign cls.illegal = ~(cls.load | cls.store | cls.rtype | cls.itype | cls.jal |
                          cls.jalr | cls.branch | cls.lui | cls.auipc);

endmodule

// File: rtl/franken_mc_control.sv
// franken_mc_control: multicycle RV32I control FSM with request/ready memory handshake.
// Defining FRANKEN_CTRL_TIMEOUT_EN adds a bus-stall watchdog that traps after TIMEOUT_CYCLES waits.
module franken_mc_control
   import franken_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       branch_taken,
   output logic       mem_req,
   output logic       mem_we,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       instr_done,
   output logic       illegal,
   output logic       timeout,
   output logic [3:0] state
);

   if (TIMEOUT_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
      $error("franken_mc_control: TIMEOUT_CYCLES must be at least 1");
   end

   state_t  cur;
   state_t  nxt;
   iclass_t cls;
   logic    req;
   logic    we;
   logic    irw;
   logic    pcw;
   logic    rw;
   logic    done;
   logic    waiting;
   logic    to_hit;

   franken_op_decode u_dec (
      .opcode (opcode),
      .cls    (cls)
   );

   // a wait cycle is any memory-access state whose request is not completed this cycle
   assign waiting = (cur == S_FETCH || cur == S_MEMRD || cur == S_MEMWR) && !mem_ready;

`ifdef FRANKEN_CTRL_TIMEOUT_EN
   logic [CNT_W-1:0] cnt;

   // trap on the TIMEOUT_CYCLES-th consecutive wait; mem_ready wins since waiting is then low
   assign to_hit = waiting && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // consecutive wait counter, cleared whenever the FSM moves
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (nxt != cur)
         cnt <= '0;
      else if (waiting)
         cnt <= cnt + CNT_W'(1);
   end

   // sticky timeout cause
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         timeout <= 1'b0;
      else if (to_hit)
         timeout <= 1'b1;
   end
`else
   assign to_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cur <= S_FETCH;
      else
         cur <= nxt;
   end

   // sticky illegal-opcode cause, latched as DECODE hands off to TRAP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         illegal <= 1'b0;
      else if (cur == S_DECODE && cls.illegal)
         illegal <= 1'b1;
   end

   // next state and per-state datapath controls
   always_comb begin
      nxt        = cur;
      req        = 1'b0;
      we         = 1'b0;
      adr_src    = 1'b0;
      irw        = 1'b0;
      pcw        = 1'b0;
      rw         = 1'b0;
      done       = 1'b0;
      alu_src_a  = A_PC;
      alu_src_b  = B_RS2;
      alu_op     = ALU_ADD;
      result_src = RES_ALUOUT;
      case (cur)
         S_FETCH: begin
            req       = 1'b1;
            alu_src_b = B_FOUR;
            if (mem_ready) begin
               irw        = 1'b1;
               pcw        = 1'b1;
               result_src = RES_ALU;
               nxt        = S_DECODE;
            end else if (to_hit) begin
               nxt = S_TRAP;
            end
         end
         S_DECODE: begin
            alu_src_a = A_OLDPC;
            alu_src_b = B_IMM;
            nxt = (cls.load | cls.store) ? S_MEMADR :
                  cls.rtype              ? S_RTYPEEX :
                  cls.itype              ? S_ITYPEEX :
                  cls.jal                ? S_JEX :
                  cls.jalr               ? S_JALREX :
                  cls.branch             ? S_BEQX :
                  (cls.lui | cls.auipc)  ? S_UEX : S_TRAP;
         end
         S_MEMADR: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            nxt       = cls.store ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            req     = 1'b1;
            adr_src = 1'b1;
            nxt     = mem_ready ? S_MEMWB : to_hit ? S_TRAP : S_MEMRD;
         end
         S_MEMWB: begin
            rw         = 1'b1;
            result_src = RES_MEM;
            done       = 1'b1;
            nxt        = S_FETCH;
         end
         S_MEMWR: begin
            req     = 1'b1;
            we      = 1'b1;
            adr_src = 1'b1;
            done    = mem_ready;
            nxt     = mem_ready ? S_FETCH : to_hit ? S_TRAP : S_MEMWR;
         end
         S_RTYPEEX: begin
            alu_src_a = A_RS1;
            alu_src_b = B_RS2;
            alu_op    = ALU_FUNCT;
            nxt       = S_ALUWB;
         end
         S_ITYPEEX: begin
            alu_src_a = A_RS1;
            alu_src_b = B_IMM;
            alu_op    = ALU_FUNCT;
            nxt       = S_ALUWB;
         end
         S_UEX: begin
            alu_src_a = cls.lui ? A_ZERO : A_OLDPC;
            alu_src_b = B_IMM;
            nxt       = S_ALUWB;
         end
         S_JEX: begin
            alu_src_a  = A_OLDPC;
            alu_src_b  = B_FOUR;
            pcw        = 1'b1;
            result_src = RES_ALUOUT;
            nxt        = S_ALUWB;
         end
         S_JALREX: begin
            alu_src_a  = A_RS1;
            alu_src_b  = B_IMM;
            pcw        = 1'b1;
            result_src = RES_ALU;
            nxt        = S_JALRWB;
         end
         S_JALRWB: begin
            alu_src_a  = A_OLDPC;
            alu_src_b  = B_FOUR;
            rw         = 1'b1;
            result_src = RES_ALU;
            done       = 1'b1;
            nxt        = S_FETCH;
         end
         S_ALUWB: begin
            rw   = 1'b1;
            done = 1'b1;
            nxt  = S_FETCH;
         end
         S_BEQX: begin
            alu_src_a = A_RS1;
            alu_src_b = B_RS2;
            alu_op    = ALU_SUB;
            pcw       = branch_taken;
            done      = 1'b1;
            nxt       = S_FETCH;
         end
         default: nxt = S_TRAP;
      endcase
   end

   // strobes are gated by reset so an in-flight access is dropped immediately
   assign mem_req    = reset & req;
   assign mem_we     = reset & we;
   assign ir_write   = reset & irw;
   assign pc_write   = reset & pcw;
   assign reg_write  = reset & rw;
   assign instr_done = reset & done;
   assign state      = cur;

endmodule

// File: tb/tb_franken_mc_control.sv
// tb_franken_mc_control: directed and randomized checks of franken_mc_control against a sequence-table model
module tb_franken_mc_control;

   localparam int TO = 4;

   localparam logic [6:0] LD  = 7'b0000011;
   localparam logic [6:0] ST  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] JR  = 7'b1100111;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] LUI = 7'b0110111;
   localparam logic [6:0] AUI = 7'b0010111;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = '0;
   logic       mem_ready = 1'b0;
   logic       branch_taken = 1'b0;
   logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
   logic       instr_done, illegal, timeout;
   logic [3:0] state;

   franken_mc_control #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .adr_src      (adr_src),
      .ir_write     (ir_write),
      .pc_write     (pc_write),
      .reg_write    (reg_write),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .alu_op       (alu_op),
      .result_src   (result_src),
      .instr_done   (instr_done),
      .illegal      (illegal),
      .timeout      (timeout),
      .state        (state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       req, we, adr, irw, pcw, rw;
      logic [1:0] a, b, op, rs;
      logic       done;
   } ov_t;

   int n_pass = 0;
   int n_total = 0;

   logic [23:0] seq_code;
   int          seq_len, pos, wcnt;
   bit          m_trap, m_ill, m_to;
   logic [6:0]  cur_op;
   logic [6:0]  dir_q[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
   endtask

   // what every instruction class walks through, as a list of state numbers
   task automatic start(input logic [6:0] op);
      cur_op = op;
      pos = 0;
      case (op)
         LD:       begin seq_code = 24'h01234; seq_len = 5; end
         ST:       begin seq_code = 24'h0125;  seq_len = 4; end
         RT:       begin seq_code = 24'h0169;  seq_len = 4; end
         IT:       begin seq_code = 24'h0179;  seq_len = 4; end
         JL:       begin seq_code = 24'h0189;  seq_len = 4; end
         JR:       begin seq_code = 24'h01BC;  seq_len = 4; end
         BR:       begin seq_code = 24'h01A;   seq_len = 3; end
         LUI, AUI: begin seq_code = 24'h01D9;  seq_len = 4; end
         default:  begin seq_code = 24'h01F;   seq_len = 3; end
      endcase
   endtask

   function automatic int mstate();
      return m_trap ? 15 : int'(seq_code[4*(seq_len-1-pos) +: 4]);
   endfunction

   function automatic logic [6:0] rand_op();
      case ($urandom_range(0, 19))
         0, 1, 2:   return LD;
         3, 4:      return ST;
         5, 6, 7:   return RT;
         8, 9, 10:  return IT;
         11, 12:    return JL;
         13, 14:    return JR;
         15, 16:    return BR;
         17:        return LUI;
         18:        return AUI;
         default:   return 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] next_op();
      if (dir_q.size() > 0) return dir_q.pop_front();
      return rand_op();
   endfunction

   // output table per state, straight from the behaviour description
   function automatic ov_t exp_out(input int st, input logic [6:0] op, input logic rdy, input logic tk);
      ov_t o;
      o = '0;
      case (st)
         0:  begin o.req = 1; o.b = 2; if (rdy) begin o.irw = 1; o.pcw = 1; o.rs = 2; end end
         1:  begin o.a = 1; o.b = 1; end
         2:  begin o.a = 2; o.b = 1; end
         3:  begin o.req = 1; o.adr = 1; end
         4:  begin o.rw = 1; o.rs = 1; o.done = 1; end
         5:  begin o.req = 1; o.we = 1; o.adr = 1; o.done = rdy; end
         6:  begin o.a = 2; o.op = 2; end
         7:  begin o.a = 2; o.b = 1; o.op = 2; end
         8:  begin o.a = 1; o.b = 2; o.pcw = 1; end
         9:  begin o.rw = 1; o.done = 1; end
         10: begin o.a = 2; o.op = 1; o.pcw = tk; o.done = 1; end
         11: begin o.a = 2; o.b = 1; o.pcw = 1; o.rs = 2; end
         12: begin o.a = 1; o.b = 2; o.rw = 1; o.rs = 2; o.done = 1; end
         13: begin o.a = (op == LUI) ? 2'd3 : 2'd1; o.b = 1; end
         default: ;
      endcase
      return o;
   endfunction

   // model step at a rising edge, using the inputs that were applied during the cycle
   task automatic advance();
      int st;
      if (!reset || m_trap) return;
      st = mstate();
      if ((st == 0 || st == 3 || st == 5) && !mem_ready) begin
         wcnt++;
`ifdef FRANKEN_CTRL_TIMEOUT_EN
         if (wcnt >= TO) begin m_trap = 1; m_to = 1; end
`endif
         return;
      end
      wcnt = 0;
      pos++;
      if (pos == seq_len) start(next_op());
      else if (mstate() == 15) begin m_trap = 1; m_ill = 1; end
   endtask

   task automatic tick(input logic rdy, input logic tk);
      mem_ready = rdy;
      branch_taken = tk;
      opcode = cur_op;
      @(negedge clk);
      #1;
   endtask

   task automatic adv();
      @(posedge clk);
      advance();
      #2;
   endtask

   task automatic do_reset(input logic [6:0] op);
      reset = 0;
      m_trap = 0; m_ill = 0; m_to = 0; wcnt = 0;
      mem_ready = 0;
      start(op);
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_illegal", 32'(illegal), 0);
      chk("rst_timeout", 32'(timeout), 0);
      @(posedge clk);
      #3;
      reset = 1;
   endtask

   // per-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (!reset) begin
         chk("inrst_state", 32'(state), 0);
         chk("inrst_strobes", 32'({mem_req, mem_we, ir_write, pc_write, reg_write, instr_done}), 0);
      end else begin
         chk("outs", 32'(ov_t'({mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                                alu_src_a, alu_src_b, alu_op, result_src, instr_done})),
             32'(exp_out(mstate(), cur_op, mem_ready, branch_taken)));
         chk("state", 32'(state), 32'(mstate()));
         chk("illegal", 32'(illegal), 32'(m_ill));
         chk("timeout", 32'(timeout), 32'(m_to));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int st_e[8];
      int lowrun;
      int tc;
      logic rdy;
      #1;
      dir_q.push_back(LD);
      dir_q.push_back(BR);
      dir_q.push_back(BR);
      dir_q.push_back(JR);
      dir_q.push_back(7'h7F);
      do_reset(RT);

      st_e = '{0, 1, 6, 9, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         tick(1, 0);
         chk("add_state", 32'(state), 32'(st_e[i]));
         chk("add_pc_write", 32'(pc_write), (i == 0) ? 1 : 0);
         chk("add_reg_write", 32'(reg_write), (i == 3) ? 1 : 0);
         chk("add_done", 32'(instr_done), (i == 3) ? 1 : 0);
         adv();
      end

      st_e = '{0, 1, 2, 3, 3, 3, 3, 4};
      for (int i = 0; i < 8; i++) begin
         tick((i >= 3 && i <= 5) ? 1'b0 : 1'b1, 0);
         chk("lw_state", 32'(state), 32'(st_e[i]));
         if (i >= 3 && i <= 6) chk("lw_adr_src", 32'(adr_src), 1);
         if (i == 7) chk("lw_wb", 32'({reg_write, result_src, instr_done}), 32'b1011);
         adv();
      end
      chk("lw_back_to_fetch", 32'(state), 0);

      for (int k = 0; k < 2; k++) begin
         st_e = '{0, 1, 10, 0, 0, 0, 0, 0};
         for (int i = 0; i < 3; i++) begin
            tick(1, 1'(k));
            chk("beq_state", 32'(state), 32'(st_e[i]));
            if (i == 2) chk("beq_pc_write", 32'(pc_write), 32'(k));
            adv();
         end
      end

      st_e = '{0, 1, 11, 12, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         tick(1, 0);
         chk("jalr_state", 32'(state), 32'(st_e[i]));
         if (i == 2) chk("jalrex", 32'({pc_write, result_src}), 32'b110);
         if (i == 3) chk("jalrwb", 32'({reg_write, alu_src_a, alu_src_b}), 32'b10110);
         adv();
      end

      st_e = '{0, 1, 15, 15, 15, 15, 0, 0};
      for (int i = 0; i < 6; i++) begin
         tick(1, 0);
         chk("ill_state", 32'(state), 32'(st_e[i]));
         if (i >= 2) chk("ill_flag", 32'({illegal, mem_req}), 32'b10);
         adv();
      end

      do_reset(ST);
      tick(0, 0);
      chk("release_req", 32'({state, mem_req}), 32'b00001);
      adv();
      for (int i = 1; i < 20; i++) begin
         tick(0, 0);
         adv();
      end
`ifdef FRANKEN_CTRL_TIMEOUT_EN
      chk("stuck_trap", 32'({state, timeout, mem_req}), 32'b111110);
`else
      chk("stuck_wait", 32'({state, timeout, mem_req}), 32'b000001);
`endif
      chk("pre_reset_req", 32'(mem_req), (mstate() == 0) ? 1 : 0);
      do_reset(rand_op());

      lowrun = 0;
      tc = 0;
      for (int n = 0; n < 1500; n++) begin
         rdy = (lowrun >= 2) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
         lowrun = rdy ? 0 : lowrun + 1;
         tick(rdy, 1'($urandom_range(0, 1)));
         adv();
         if (m_trap) begin
            tc++;
            if (tc >= 3) begin
               tc = 0;
               do_reset(rand_op());
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
